instr_fifo: RTL and testbench
=============================

# instr_fifo

Host-command buffer sitting directly upstream of the memory controller (MC). Packs 16-bit host pipe-in half-words into 32-bit instruction words, buffers them in a first-word-fall-through FIFO, and presents them on MC's `din`/`din_empty`/`din_wr` interface. MC pops one word per `din_wr` strobe.

## Interface
- `ADDR_W`, 8: log2 of FIFO depth; depth = 2^ADDR_W words.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous flush of FIFO, pointers, packer and flags.
- `hw_wr`  in  1  host half-word write strobe, one half-word per cycle when high.
- `hw_data`  in  16  host half-word.
- `rd`  in  1  pop strobe; driven by MC `din_wr`.
- `dout`  out  32  head word; drives MC `din`.
- `empty`  out  1  no word available; drives MC `din_empty`.
- `full`  out  1  2^ADDR_W words stored.
- `count`  out  ADDR_W+1  words stored.
- `overflow`  out  1  sticky: a completed word was dropped because the FIFO was full.
- `half_pend`  out  1  low half-word held, waiting for its high half.
- `cksum`  out  32  running XOR of accepted words (present only with `INSTR_FIFO_CKSUM_EN`).

## Operation
- Packer: first `hw_wr` latches `hw_data` as bits [15:0] and sets `half_pend`. The second latches bits [31:16], forms the word and issues one push. `half_pend` toggles on every `hw_wr`.
- Push when full: the word is dropped, `overflow` is set, and the packer is still consumed (`half_pend` returns to 0).
- Storage: 2^ADDR_W x 32 distributed-RAM array. Write pointer and read pointer are each ADDR_W+1 bits and wrap modulo 2^(ADDR_W+1).
  - `full` = pointers differ only in their MSB.
  - `empty` = pointers are equal.
- FWFT read: `dout` = mem[rd_ptr[ADDR_W-1:0]] combinationally, valid whenever `empty`=0. `rd` with `empty`=1 is ignored.
- Simultaneous push and pop:
  - Full/empty are evaluated on the pre-edge state.
  - When full, the push is dropped even though a pop occurs in the same cycle.
  - When empty, the push is accepted and the pop is ignored.
  - Otherwise both happen and `count` is unchanged.
- `clear`: pointers, `count`, `half_pend`, `overflow` and `cksum` go to 0 on the next edge. `clear` has priority over a simultaneous `hw_wr`/`rd`. RAM contents are not cleared.
- Reset (`rst`=0, any time, including with a half-word pending): same effect as `clear`, asynchronously.
  - Output values under reset: `empty`=1, `full`=0, `count`=0, `overflow`=0, `half_pend`=0, `cksum`=0.
  - `dout` is undefined under reset.

## Timing
- Push latency: high half-word written at edge N gives `empty`=0 and a valid `dout` after edge N+1. The packer register stage adds one cycle.
- Pop: `rd` sampled at edge N; the next word is on `dout`, or `empty`=1, after edge N.
- `empty`, `full`, `count` and `overflow` are registered outputs. `count` changes in the same cycle as the pointer it reflects.
- Sustained throughput: one word per two `hw_wr` cycles in; one word per cycle out.

## Configuration
- `INSTR_FIFO_CKSUM_EN` defined:
  - `cksum` port exists.
  - On every accepted push (not dropped ones), `cksum` <= `cksum` ^ word. The new value appears on the edge the word enters the RAM.
  - Cleared by `clear`/`rst`.
- Undefined: `cksum` port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `instr_fifo_pkg`: `WORD_W`=32, `HALF_W`=16, default `ADDR_W`=8.
- One natural sub-module `instr_pack`: the half-word assembler.
  - Inputs: `hw_wr`, `hw_data`, `clear`.
  - Outputs: `push`, `word[31:0]`, `half_pend`.
- Storage, pointers, flags and checksum live in `instr_fifo`.

## Test plan
- Packing: reset, then write half-words 0x5678 then 0x1234 → after 2 more edges `empty`=0, `dout`=0x12345678, `count`=1. Pulse `rd` → `empty`=1.
- Fill/overflow: with `ADDR_W`=2, push 4 words → `full`=1, `count`=4. Push a 5th → dropped, `overflow`=1. Pop 4 → order intact; `overflow` stays 1.
- Simultaneous push+pop: at `count`=2 → `count` stays 2 and order is preserved. At full → push dropped, `count`=3, `overflow`=1.
- Pointer wrap: `ADDR_W`=2, 20 push/pop pairs with incrementing data → every `dout` matches, `full` never asserted.
- Mid-operation reset/clear: write one half-word (`half_pend`=1), then assert `clear` → `half_pend`=0. Next two half-words 0xAAAA, 0xBBBB give 0xBBBBAAAA. Repeat with async `rst` low between edges → outputs reach reset values immediately.
- Checksum (`INSTR_FIFO_CKSUM_EN`): push 0x0000FFFF then 0xFFFF0000 → `cksum`=0xFFFFFFFF. Push a dropped word while full → `cksum` unchanged.

Source files
------------

// File: rtl/instr_fifo_pkg.sv
// Shared widths and defaults for the instruction FIFO slice.
package instr_fifo_pkg;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned HALF_W     = 16;
    localparam int          DEF_ADDR_W = 8;
endpackage

// File: rtl/instr_fifo_if.sv
// Host/MC-facing signal bundle of instr_fifo.
// Optional checksum port present when INSTR_FIFO_CKSUM_EN is defined.
interface instr_fifo_if
    import instr_fifo_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              clear;
    logic              hw_wr;
    logic [HALF_W-1:0] hw_data;
    logic              rd;
    logic [WORD_W-1:0] dout;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              half_pend;
`ifdef INSTR_FIFO_CKSUM_EN
    logic [WORD_W-1:0] cksum;

    modport master (output clear, hw_wr, hw_data, rd,
                    input  dout, empty, full, count, overflow, half_pend, cksum);
    modport slave  (input  clear, hw_wr, hw_data, rd,
                    output dout, empty, full, count, overflow, half_pend, cksum);
`else
    modport master (output clear, hw_wr, hw_data, rd,
                    input  dout, empty, full, count, overflow, half_pend);
    modport slave  (input  clear, hw_wr, hw_data, rd,
                    output dout, empty, full, count, overflow, half_pend);
`endif
endinterface

// File: rtl/instr_pack.sv
// Half-word assembler: two host half-words (low first) form one 32-bit
// word, issued as a single-cycle registered push.
module instr_pack
    import instr_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              hw_wr,
    input  logic [HALF_W-1:0] hw_data,
    output logic              push,
    output logic [WORD_W-1:0] word,
    output logic              half_pend
);
    logic [HALF_W-1:0] lo_q;
    logic              pend_q;
    logic              push_q;
    logic [WORD_W-1:0] word_q;

    // Latch the low half, then on the high half emit the word and a push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo_q   <= '0;
            pend_q <= 1'b0;
            push_q <= 1'b0;
            word_q <= '0;
        end else if (clear) begin
            pend_q <= 1'b0;
            push_q <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (hw_wr) begin
                pend_q <= ~pend_q;
                if (!pend_q) begin
                    lo_q <= hw_data;
                end else begin
                    word_q <= {hw_data, lo_q};
                    push_q <= 1'b1;
                end
            end
        end
    end

    assign push      = push_q;
    assign word      = word_q;
    assign half_pend = pend_q;
endmodule

// File: rtl/instr_fifo.sv
// FWFT instruction FIFO feeding the memory controller.
// Define INSTR_FIFO_CKSUM_EN to add the running-XOR checksum output.
module instr_fifo
    import instr_fifo_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
)(
    input  logic         clk,
    input  logic         rst,
    instr_fifo_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic              pk_push;
    logic [WORD_W-1:0] pk_word;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              ovf_q, ovf_d;
    logic              do_push, do_pop;

    instr_pack u_pack (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.clear),
        .hw_wr     (bus.hw_wr),
        .hw_data   (bus.hw_data),
        .push      (pk_push),
        .word      (pk_word),
        .half_pend (bus.half_pend)
    );

    // Accept/pop qualification on pre-edge flags; clear overrides both.
    always_comb begin
        do_push = pk_push && !full_q && !bus.clear;
        do_pop  = bus.rd && !empty_q && !bus.clear;
    end

    // Next pointers, count and flags; flags are derived from next pointers
    // so they can be registered alongside them.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (bus.clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(1);
            if (do_push && !do_pop) count_d = count_q + (ADDR_W+1)'(1);
            if (!do_push && do_pop) count_d = count_q - (ADDR_W+1)'(1);
            if (pk_push && full_q)  ovf_d   = 1'b1;
        end
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
                  (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array, no reset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= pk_word;
    end

`ifdef INSTR_FIFO_CKSUM_EN
    logic [WORD_W-1:0] cksum_q;

    // Running XOR over accepted words only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           cksum_q <= '0;
        else if (bus.clear) cksum_q <= '0;
        else if (do_push)   cksum_q <= cksum_q ^ pk_word;
    end

    assign bus.cksum = cksum_q;
`endif

    assign bus.dout     = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_instr_fifo.sv
// Directed self-checking bench for instr_fifo (ADDR_W = 2).
module tb_instr_fifo;
    import instr_fifo_pkg::*;

    localparam int AW = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    instr_fifo_if #(.ADDR_W(AW)) bus ();

    instr_fifo #(.ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_hw(input logic [15:0] d);
        bus.hw_wr   = 1'b1;
        bus.hw_data = d;
        tick();
        bus.hw_wr   = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        write_hw(w[15:0]);
        write_hw(w[31:16]);
    endtask

    task automatic pop();
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b0;
        bus.clear   = 1'b0;
        bus.hw_wr   = 1'b0;
        bus.hw_data = '0;
        bus.rd      = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_empty",  32'(bus.empty), 32'd1);
        check("rst_full",   32'(bus.full), 32'd0);
        check("rst_count",  32'(bus.count), 32'd0);
        check("rst_ovf",    32'(bus.overflow), 32'd0);
        check("rst_pend",   32'(bus.half_pend), 32'd0);
        #2 rst = 1'b1;
        tick();

        // Packing and latency
        write_hw(16'h5678);
        check("pk_pend1", 32'(bus.half_pend), 32'd1);
        write_hw(16'h1234);
        check("pk_pend0", 32'(bus.half_pend), 32'd0);
        check("pk_lat_empty", 32'(bus.empty), 32'd1);
        tick();
        check("pk_empty", 32'(bus.empty), 32'd0);
        check("pk_dout",  bus.dout, 32'h12345678);
        check("pk_count", 32'(bus.count), 32'd1);
        pop();
        check("pk_pop_empty", 32'(bus.empty), 32'd1);
        check("pk_pop_count", 32'(bus.count), 32'd0);

        // Fill and overflow
        for (int i = 0; i < 4; i++) push_word(32'h11110000 + 32'(i));
        tick();
        check("fill_full",  32'(bus.full), 32'd1);
        check("fill_count", 32'(bus.count), 32'd4);
        check("fill_ovf0",  32'(bus.overflow), 32'd0);
        push_word(32'hDEADBEEF);
        tick();
        check("ovf_set",   32'(bus.overflow), 32'd1);
        check("ovf_count", 32'(bus.count), 32'd4);
        check("ovf_pend",  32'(bus.half_pend), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("fill_order", bus.dout, 32'h11110000 + 32'(i));
            pop();
        end
        check("drain_empty", 32'(bus.empty), 32'd1);
        check("drain_ovf",   32'(bus.overflow), 32'd1);

        // Simultaneous push and pop at count 2
        do_clear();
        check("clr_ovf",   32'(bus.overflow), 32'd0);
        check("clr_empty", 32'(bus.empty), 32'd1);
        push_word(32'hB0B0B0B0);
        push_word(32'hB1B1B1B1);
        tick();
        check("pp_count2", 32'(bus.count), 32'd2);
        push_word(32'hB2B2B2B2);
        pop();
        check("pp_count_same", 32'(bus.count), 32'd2);
        check("pp_head1", bus.dout, 32'hB1B1B1B1);
        pop();
        check("pp_head2", bus.dout, 32'hB2B2B2B2);
        pop();
        check("pp_empty", 32'(bus.empty), 32'd1);

        // Simultaneous push and pop while full
        for (int i = 0; i < 4; i++) push_word(32'hC0C00000 + 32'(i));
        tick();
        check("pf_full", 32'(bus.full), 32'd1);
        push_word(32'hC4C4C4C4);
        pop();
        check("pf_count", 32'(bus.count), 32'd3);
        check("pf_ovf",   32'(bus.overflow), 32'd1);
        check("pf_full0", 32'(bus.full), 32'd0);
        for (int i = 1; i < 4; i++) begin
            check("pf_order", bus.dout, 32'hC0C00000 + 32'(i));
            pop();
        end
        check("pf_empty", 32'(bus.empty), 32'd1);

        // Pointer wrap
        do_clear();
        for (int i = 0; i < 20; i++) begin
            push_word(32'hD0000000 + 32'(i));
            tick();
            check("wrap_dout", bus.dout, 32'hD0000000 + 32'(i));
            check("wrap_full", 32'(bus.full), 32'd0);
            pop();
            check("wrap_empty", 32'(bus.empty), 32'd1);
        end

        // Clear with a half-word pending
        write_hw(16'h9999);
        check("mc_pend1", 32'(bus.half_pend), 32'd1);
        do_clear();
        check("mc_pend0", 32'(bus.half_pend), 32'd0);
        push_word(32'hBBBBAAAA);
        tick();
        check("mc_dout",  bus.dout, 32'hBBBBAAAA);
        check("mc_count", 32'(bus.count), 32'd1);

        // Async reset between edges with a word stored and a half pending
        write_hw(16'h7777);
        check("ar_pend1", 32'(bus.half_pend), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("ar_empty", 32'(bus.empty), 32'd1);
        check("ar_count", 32'(bus.count), 32'd0);
        check("ar_pend",  32'(bus.half_pend), 32'd0);
        check("ar_full",  32'(bus.full), 32'd0);
        check("ar_ovf",   32'(bus.overflow), 32'd0);
        #1 rst = 1'b1;
        tick();
        push_word(32'hBBBBAAAA);
        tick();
        check("ar_dout",  bus.dout, 32'hBBBBAAAA);
        check("ar_count1", 32'(bus.count), 32'd1);

`ifdef INSTR_FIFO_CKSUM_EN
        // Checksum over accepted words only
        do_clear();
        check("ck_clr", bus.cksum, 32'h0);
        push_word(32'h0000FFFF);
        push_word(32'hFFFF0000);
        tick();
        check("ck_pair", bus.cksum, 32'hFFFFFFFF);
        push_word(32'h00000001);
        push_word(32'h00000002);
        tick();
        check("ck_four", bus.cksum, 32'hFFFFFFFC);
        push_word(32'h12345678);
        tick();
        check("ck_drop", bus.cksum, 32'hFFFFFFFC);
        check("ck_ovf",  32'(bus.overflow), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
